// File: rtl/reset_pulse_gen_pkg.sv
// rtl/reset_pulse_gen_pkg.sv - shared state and cause encodings for the reset pulse generator
package reset_pulse_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_e;

   localparam logic [1:0] CAUSE_NONE = 2'd0;
   localparam logic [1:0] CAUSE_EXT  = 2'd1;
   localparam logic [1:0] CAUSE_SW   = 2'd2;
   localparam logic [1:0] CAUSE_WDT  = 2'd3;

   localparam logic [7:0] RST_COUNT_MAX = 8'hFF;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == RST_COUNT_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/reset_pulse_gen_down_counter.sv
// rtl/reset_pulse_gen_down_counter.sv - loadable down counter with zero flag
module down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec_en,
   output logic             zero
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_en) begin
         cnt_d = load_val;
      end else if (dec_en) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/reset_pulse_gen.sv
// rtl/reset_pulse_gen.sv - merges external, software and watchdog reset requests
// into fixed-width reset pulses followed by a hold-off window.
module reset_pulse_gen
   import reset_pulse_gen_pkg::*;
#(
   parameter logic RST_OUT_POLARITY = 1'b1,
   parameter int   PULSE_CYCLES     = 16,
   parameter int   HOLDOFF_CYCLES   = 8,
   parameter int   WDT_CYCLES       = 1024,
   parameter logic WDT_EN           = 1'b1
) (
   input  logic       clkIn,
   input  logic       rstIn,
   input  logic       swRstReqIn,
   input  logic       wdtKickIn,
   output logic       rstOut,
   output logic       busyOut,
   output logic [1:0] causeOut,
   output logic [7:0] rstCountOut
);

   localparam int CNT_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam int WDT_W   = $clog2(WDT_CYCLES);

   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF_CYCLES - 1);
   localparam logic [WDT_W-1:0] WDT_LAST   = WDT_W'(WDT_CYCLES - 1);

   state_e           state_q, state_d;
   logic [1:0]       cause_q, cause_d;
   logic [7:0]       count_q, count_d;
   logic [WDT_W-1:0] wdt_q, wdt_d;
   logic             rst_out_q, rst_out_d;
   logic             busy_q, busy_d;

   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_dec;
   logic             cnt_zero;
   logic             wdt_expire;

   down_counter #(.WIDTH(CNT_W)) u_pulse_cnt (
      .clk      (clkIn),
      .load_en  (cnt_load),
      .load_val (cnt_load_val),
      .dec_en   (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d      = state_q;
      cause_d      = cause_q;
      count_d      = count_q;
      wdt_d        = '0;
      cnt_load     = rstIn;
      cnt_load_val = PULSE_LOAD;
      cnt_dec      = 1'b0;
      wdt_expire   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A kick in the expiry cycle still rescues the system.
            wdt_expire = WDT_EN && !wdtKickIn && (wdt_q == WDT_LAST);
            if (swRstReqIn) begin
               state_d  = ST_ASSERT;
               cnt_load = 1'b1;
               cause_d  = CAUSE_SW;
               count_d  = sat_inc(count_q);
            end else if (wdt_expire) begin
               state_d  = ST_ASSERT;
               cnt_load = 1'b1;
               cause_d  = CAUSE_WDT;
               count_d  = sat_inc(count_q);
            end else if (WDT_EN && !wdtKickIn) begin
               wdt_d = wdt_q + 1'b1;
            end
         end
         ST_ASSERT: begin
            if (cnt_zero) begin
               state_d      = ST_HOLDOFF;
               cnt_load     = 1'b1;
               cnt_load_val = rstIn ? PULSE_LOAD : HOLD_LOAD;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_HOLDOFF: begin
            if (cnt_zero) begin
               state_d = ST_IDLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      rst_out_d = (state_d == ST_ASSERT) ? RST_OUT_POLARITY : ~RST_OUT_POLARITY;
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         state_q   <= ST_ASSERT;
         cause_q   <= CAUSE_EXT;
         count_q   <= 8'd0;
         wdt_q     <= '0;
         rst_out_q <= RST_OUT_POLARITY;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cause_q   <= cause_d;
         count_q   <= count_d;
         wdt_q     <= wdt_d;
         rst_out_q <= rst_out_d;
         busy_q    <= busy_d;
      end
   end

   assign rstOut      = rst_out_q;
   assign busyOut     = busy_q;
   assign causeOut    = cause_q;
   assign rstCountOut = count_q;

endmodule

// File: tb/tb_reset_pulse_gen.sv
// tb/tb_reset_pulse_gen.sv - directed bench for reset_pulse_gen
module tb_reset_pulse_gen;
   import reset_pulse_gen_pkg::*;

   localparam int P = 16;
   localparam int H = 8;
   localparam int W = 64;
   localparam int NVEC = 25;

   typedef struct {
      logic       sw;
      logic       exp_rst;
      logic       exp_busy;
      logic [1:0] exp_cause;
      logic [7:0] exp_cnt;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst, sw, kick;
   logic       rst_out, busy;
   logic [1:0] cause;
   logic [7:0] cnt;

   logic       rst1;
   logic       sw1 = 1'b0;
   logic       kick1 = 1'b0;
   logic       rst_out1, busy1;
   logic [1:0] cause1;
   logic [7:0] cnt1;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int dut1_pulses = 0;
   vec_t vecs[NVEC];

   always #5 clk = ~clk;

   reset_pulse_gen #(
      .RST_OUT_POLARITY(1'b1), .PULSE_CYCLES(P), .HOLDOFF_CYCLES(H),
      .WDT_CYCLES(W), .WDT_EN(1'b1)
   ) u_dut (
      .clkIn(clk), .rstIn(rst), .swRstReqIn(sw), .wdtKickIn(kick),
      .rstOut(rst_out), .busyOut(busy), .causeOut(cause), .rstCountOut(cnt)
   );

   reset_pulse_gen #(
      .RST_OUT_POLARITY(1'b0), .PULSE_CYCLES(P), .HOLDOFF_CYCLES(H),
      .WDT_CYCLES(W), .WDT_EN(1'b0)
   ) u_dut_nowdt (
      .clkIn(clk), .rstIn(rst1), .swRstReqIn(sw1), .wdtKickIn(kick1),
      .rstOut(rst_out1), .busyOut(busy1), .causeOut(cause1), .rstCountOut(cnt1)
   );

   always @(negedge clk) begin
      cyc++;
      if (cyc > 40 && rst_out1 == 1'b0) dut1_pulses++;
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 200) begin
         tick();
         k++;
      end
      if (busy) check("idle_timeout", int'(busy), 0);
   endtask

   task automatic measure(output int act_len, output int busy_len);
      act_len  = 0;
      busy_len = 0;
      for (int k = 0; k < 200 && busy; k++) begin
         if (rst_out) act_len++;
         busy_len++;
         tick();
      end
   endtask

   task automatic idle_ticks(input int n, output int pulses);
      pulses = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         if (rst_out) pulses++;
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int a, b, pulses;

      for (int k = 0; k < NVEC; k++) begin
         vecs[k].sw        = (k == 0 || k == 18);
         vecs[k].exp_rst   = (k < P);
         vecs[k].exp_busy  = (k < P + H);
         vecs[k].exp_cause = CAUSE_SW;
         vecs[k].exp_cnt   = 8'd1;
      end

      // power-up reset on both instances
      rst = 1'b1; rst1 = 1'b1; sw = 1'b0; kick = 1'b0;
      tick();
      check("por_rst", int'(rst_out), 1);
      check("por_busy", int'(busy), 1);
      check("por_cause", int'(cause), 1);
      check("por_cnt", int'(cnt), 0);
      check("por_rst_active_low", int'(rst_out1), 0);
      tick();
      tick();
      rst = 1'b0; rst1 = 1'b0;
      measure(a, b);
      check("por_pulse_len", a, P);
      check("por_busy_len", b, P + H);
      check("por_cause_after", int'(cause), 1);
      check("por_cnt_after", int'(cnt), 0);
      check("por_released_active_low", int'(rst_out1), 1);

      // SW request trace with a dropped request in hold-off
      for (int k = 0; k < NVEC; k++) begin
         sw = vecs[k].sw;
         tick();
         sw = 1'b0;
         check($sformatf("vec%0d_rst", k), int'(rst_out), int'(vecs[k].exp_rst));
         check($sformatf("vec%0d_busy", k), int'(busy), int'(vecs[k].exp_busy));
         check($sformatf("vec%0d_cause", k), int'(cause), int'(vecs[k].exp_cause));
         check($sformatf("vec%0d_cnt", k), int'(cnt), int'(vecs[k].exp_cnt));
      end

      // watchdog expiry with no kicks: pulse starts W cycles after IDLE entry
      idle_ticks(W - 1, pulses);
      check("wdt_early_pulse", pulses, 0);
      tick();
      check("wdt_fire_rst", int'(rst_out), 1);
      check("wdt_cause", int'(cause), 3);
      check("wdt_cnt", int'(cnt), 2);
      measure(a, b);
      check("wdt_pulse_len", a, P);
      check("wdt_busy_len", b, P + H);

      // kicks every 50 cycles keep the watchdog quiet
      pulses = 0;
      for (int i = 0; i < 1000; i++) begin
         kick = (i % 50 == 49);
         tick();
         if (rst_out) pulses++;
      end
      kick = 1'b0;
      check("kick_no_pulse", pulses, 0);

      // SW request in the same cycle as watchdog expiry
      idle_ticks(W - 1, pulses);
      check("sw_wdt_early_pulse", pulses, 0);
      sw = 1'b1;
      tick();
      sw = 1'b0;
      check("sw_wdt_rst", int'(rst_out), 1);
      check("sw_wdt_cause", int'(cause), 2);
      check("sw_wdt_cnt", int'(cnt), 3);
      measure(a, b);
      check("sw_wdt_pulse_len", a, P);
      check("sw_wdt_busy_len", b, P + H);

      // kick in the same cycle as expiry
      idle_ticks(W - 1, pulses);
      kick = 1'b1;
      tick();
      kick = 1'b0;
      check("kick_exp_rst", int'(rst_out), 0);
      check("kick_exp_busy", int'(busy), 0);
      idle_ticks(10, pulses);
      check("kick_exp_later", pulses, 0);
      check("kick_exp_cnt", int'(cnt), 3);

      // rstIn mid-pulse restarts the pulse as EXT and clears the count
      sw = 1'b1;
      tick();
      sw = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      measure(a, b);
      check("mid_pulse_len", a, P);
      check("mid_busy_len", b, P + H);
      check("mid_cause", int'(cause), 1);
      check("mid_cnt", int'(cnt), 0);

      // saturating pulse count
      for (int i = 1; i <= 300; i++) begin
         wait_idle();
         sw = 1'b1;
         tick();
         sw = 1'b0;
         if (i == 1 || i == 255 || i == 256 || i == 300)
            check($sformatf("sat_cnt_%0d", i), int'(cnt), (i > 255) ? 255 : i);
      end
      wait_idle();

      check("nowdt_run_length", int'(cyc > 5000), 1);
      check("nowdt_no_pulse", dut1_pulses, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
